// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared constants for the multi-core DMEM arbiter: default widths and the
// helper that sizes port-index fields.
package dmem_rr_arbiter_pkg;

  localparam int DEFAULT_NUM_PORTS = 2;
  localparam int DEFAULT_ADDR_W    = 32;
  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_CNT_W     = 32;

  // A single-port configuration still needs a 1-bit index field.
  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  localparam int PORT_IDX_W = port_idx_w(DEFAULT_NUM_PORTS);

endpackage

// File: rtl/dmem_rr_arbiter_picker.sv
// Combinational round-robin picker: first requesting port at or after ptr,
// wrapping modulo NUM_PORTS, returned as one-hot grant plus index.
module dmem_rr_arbiter_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [NUM_PORTS-1:0] rot;
  logic [IDX_W-1:0]     first;
  logic [IDX_W:0]       sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot   = NUM_PORTS'({req, req} >> ptr);
    first = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any && rot[i]) begin
        any   = 1'b1;
        first = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, first};
    if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
      sum = sum - (IDX_W+1)'(NUM_PORTS);
    end
    idx = sum[IDX_W-1:0];
    gnt = any ? (NUM_PORTS'(1) << idx) : '0;
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency DMEM among
// NUM_PORTS core data ports, with registered read routing and a contention counter.
module dmem_rr_arbiter
  import dmem_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          dmem_we,
  output logic [ADDR_W-1:0]             dmem_addr,
  output logic [DATA_W-1:0]             dmem_wdata,
  input  logic [DATA_W-1:0]             dmem_rdata,
  output logic [CNT_W-1:0]              contention
);

  localparam int IDX_W = port_idx_w(NUM_PORTS);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     resp_port;
  logic                 resp_valid;
  logic                 grant_any;
  logic [NUM_PORTS-1:0] req_eff;
  logic [NUM_PORTS-1:0] gnt_int;
  logic                 multi_req;

  // Reset and a low enable both hide requests, so no grant and no write strobe.
  assign req_eff = (ena && !reset) ? req : '0;

  dmem_rr_arbiter_picker #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req(req_eff),
    .ptr(rr_ptr),
    .gnt(gnt_int),
    .idx(grant_idx),
    .any(grant_any)
  );

  assign gnt     = gnt_int;
  assign dmem_we = |(gnt_int & we);
  assign rdata   = dmem_rdata;

  // Idle bus parks on port 0 so the DMEM address is never undriven.
  always_comb begin
    dmem_addr  = addr[ADDR_W-1:0];
    dmem_wdata = wdata[DATA_W-1:0];
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_int[p]) begin
        dmem_addr  = addr[p*ADDR_W +: ADDR_W];
        dmem_wdata = wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_port  <= '0;
    end else begin
      resp_valid <= grant_any && !dmem_we;
      if (grant_any) begin
        resp_port <= grant_idx;
      end
    end
  end

  // Masking with reset drops a response that is still in flight when reset hits.
  always_comb begin
    rvalid = '0;
    if (resp_valid && !reset) begin
      rvalid[resp_port] = 1'b1;
    end
  end

  assign multi_req = ($countones(req) > 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      contention <= '0;
    end else if (ena && multi_req && (contention != '1)) begin
      contention <= contention + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural round-robin/memory model.
module tb_dmem_rr_arbiter;

  localparam int NP = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             ena;
  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             dmem_we;
  logic [AW-1:0]    dmem_addr;
  logic [DW-1:0]    dmem_wdata;
  logic [DW-1:0]    dmem_rdata;
  logic [CW-1:0]    contention;

  always #5 clk = ~clk;

  dmem_rr_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .contention(contention)
  );

  function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
    return {4{a}} ^ 32'hA5A55A5A;
  endfunction

  // DMEM stub: clocked single port, unwritten words read as initWord(addr).
  logic [DW-1:0] mem [256];
  bit            written [256];
  always @(posedge clk) begin
    if (dmem_we) begin
      mem[dmem_addr]     <= dmem_wdata;
      written[dmem_addr] <= 1'b1;
    end
    dmem_rdata <= written[dmem_addr] ? mem[dmem_addr] : initWord(dmem_addr);
  end

  // Per-port request state driven by the stimulus code.
  logic          p_req   [NP];
  logic          p_we    [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  int            m_ptr;
  int            m_cont;
  bit            pend_valid;
  int            pend_port;
  logic [DW-1:0] pend_data;
  int            last_g;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < NP; p++) begin
      req[p]               = p_req[p];
      we[p]                = p_we[p];
      addr[p*AW +: AW]     = p_addr[p];
      wdata[p*DW +: DW]    = p_wdata[p];
    end
  endtask

  // One clock cycle: check this cycle's outputs against the model, then advance it.
  task automatic stepCycle();
    int g;
    int nreq;
    #1;
    checkOutput("rvalid", rvalid, (pend_valid && !reset) ? (64'd1 << pend_port) : 64'd0);
    if (pend_valid && !reset) checkOutput("rdata", rdata, pend_data);
    checkOutput("contention", contention, m_cont);

    g = -1;
    nreq = 0;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (!reset && ena && g < 0 && p_req[p]) g = p;
      if (p_req[k]) nreq++;
    end
    checkOutput("gnt", gnt, (g < 0) ? 64'd0 : (64'd1 << g));
    checkOutput("dmem_we", dmem_we, (g >= 0) && p_we[g]);
    if (g >= 0) begin
      checkOutput("dmem_addr", dmem_addr, p_addr[g]);
      if (p_we[g]) checkOutput("dmem_wdata", dmem_wdata, p_wdata[g]);
    end else begin
      checkOutput("dmem_addr_idle", dmem_addr, p_addr[0]);
    end

    if (reset) begin
      m_ptr = 0;
      m_cont = 0;
      pend_valid = 0;
    end else begin
      pend_valid = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % NP;
        if (p_we[g]) begin
          ref_mem[p_addr[g]] = p_wdata[g];
        end else begin
          pend_valid = 1;
          pend_port  = g;
          pend_data  = ref_mem[p_addr[g]];
        end
      end
      if (ena && nreq >= 2 && m_cont < CNT_MAX) m_cont++;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setPort(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[p] = r; p_we[p] = w; p_addr[p] = a; p_wdata[p] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(AW'(i));
    for (int p = 0; p < NP; p++) setPort(p, 1'b0, 1'b0, '0, '0);
    m_ptr = 0; m_cont = 0; pend_valid = 0; pend_port = 0; pend_data = '0; last_g = -1;
    reset = 1'b1;
    ena   = 1'b1;
    applyStimulus();
    @(negedge clk);
    stepCycle();
    stepCycle();
    reset = 1'b0;

    // Single uncontended read.
    setPort(0, 1'b1, 1'b0, 8'h10, '0);
    applyStimulus();
    #1 checkOutput("single_gnt", gnt, 2'b01);
    stepCycle();
    checkOutput("single_rvalid", rvalid, 2'b01);
    checkOutput("single_rdata", rdata, initWord(8'h10));
    p_req[0] = 1'b0;

    // Both ports read every cycle from a fresh reset; counter saturates.
    reset = 1'b1;
    applyStimulus();
    stepCycle();
    reset = 1'b0;
    setPort(0, 1'b1, 1'b0, 8'h01, '0);
    setPort(1, 1'b1, 1'b0, 8'h02, '0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      #1 checkOutput("alt_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      stepCycle();
    end
    checkOutput("sat_contention", contention, 4'hF);
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;

    // Write from port 1, read back on port 0.
    setPort(1, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
    applyStimulus();
    stepCycle();
    checkOutput("write_no_rvalid", rvalid, 2'b00);
    p_req[1] = 1'b0;
    setPort(0, 1'b1, 1'b0, 8'h20, '0);
    applyStimulus();
    stepCycle();
    checkOutput("wr_rd_rvalid", rvalid, 2'b01);
    checkOutput("wr_rd_rdata", rdata, 32'hDEADBEEF);
    p_req[0] = 1'b0;
    applyStimulus();
    stepCycle();

    // Enable dropped right after a read grant.
    setPort(0, 1'b1, 1'b0, 8'h05, '0);
    applyStimulus();
    stepCycle();
    ena = 1'b0;
    setPort(0, 1'b1, 1'b0, 8'h07, '0);
    setPort(1, 1'b1, 1'b0, 8'h06, '0);
    applyStimulus();
    #1 checkOutput("ena_rvalid", rvalid, 2'b01);
    checkOutput("ena_gnt", gnt, 2'b00);
    stepCycle();
    stepCycle();
    ena = 1'b1;
    applyStimulus();
    #1 checkOutput("ena_resume_gnt", gnt, 2'b10);
    stepCycle();
    p_req[1] = 1'b0;
    applyStimulus();
    stepCycle();
    p_req[0] = 1'b0;
    applyStimulus();
    stepCycle();

    // Reset right after a read grant drops the response.
    setPort(1, 1'b1, 1'b0, 8'h09, '0);
    applyStimulus();
    stepCycle();
    p_req[1] = 1'b0;
    reset = 1'b1;
    applyStimulus();
    #1 checkOutput("reset_drop_rvalid", rvalid, 2'b00);
    stepCycle();
    reset = 1'b0;
    setPort(0, 1'b1, 1'b0, 8'h0A, '0);
    setPort(1, 1'b1, 1'b0, 8'h0B, '0);
    applyStimulus();
    #1 checkOutput("post_reset_gnt", gnt, 2'b01);
    checkOutput("post_reset_cont", contention, 4'h0);
    stepCycle();
    p_req[0] = 1'b0;

    // Randomized traffic obeying the hold-until-granted handshake.
    for (int c = 0; c < 400; c++) begin
      ena   = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NP; p++) begin
        if (!p_req[p] && $urandom_range(0, 2) != 0) begin
          setPort(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
      end
      applyStimulus();
      stepCycle();
      if (last_g >= 0) p_req[last_g] = 1'b0;
    end

    reset = 1'b0;
    for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
    applyStimulus();
    stepCycle();
    stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
